lock_code_ctrl: RTL
===================

Name: lock_code_ctrl

Overview:
Keypad-driven access controller for the door-lock subsystem. It sits between the raw 12-key active-low keypad and the door actuator. It sequences code entry, holds a user-programmable secret code, counts failed attempts and enforces a lockout window. It also auto-relocks after a timed open window and supports a program/confirm flow for changing the code.

Parameters:
DIGITS, 3, code length in digits (1..8)
INIT_CODE, 12'h481, reset code, 4 bits per digit, first-entered digit in MS nibble (width DIGITS*4)
REL_CYC, 24'hFFFFFF, consecutive all-released cycles required before the next key is accepted
OPEN_CYC, 50000000, cycles open stays high
MAX_FAIL, 3, consecutive failed entries that trigger lockout (>=1)
LOCKOUT_CYC, 250000000, lockout duration in cycles

Ports:
clk  in  1  clock
n_reset  in  1  reset, asynchronous, active-low
key_n  in  12  keypad, active-low; bits 0-8 = digits 1-9, bit 9 = digit 0, bit 10 = '#', bit 11 = '*'
open  out  1  door release
lockout  out  1  high while in LOCKOUT
prog_mode  out  1  high in PROG or CONFIRM
digit_cnt  out  3  digits collected in the current entry
fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failures
code_chg  out  1  one-cycle pulse when a new code is committed
err  out  1  one-cycle pulse on entry mismatch or confirm mismatch

Behaviour:
- Reset (async): state = IDLE; code = INIT_CODE; all outputs 0; all counters 0; release-armed = 1.
- Key scan:
  - key_n passes through a 2-flop synchronizer.
  - A key event occurs when the synced value has exactly one bit low and release-armed = 1.
  - Key codes: digit 0-9 -> 0-9, '#' -> 10, '*' -> 11.
  - An accepted event clears release-armed.
  - rel_cnt counts consecutive cycles with synced value == 12'hFFF; any other value zeroes it. When rel_cnt reaches REL_CYC, release-armed is set.
  - Multi-key patterns never produce an event.
- Outputs are Moore, registered from state. A key_n change is visible on outputs at the 3rd clk edge.
- States and transitions (events not listed are ignored):
  - IDLE:
    - '*' -> ENTRY with digit_cnt = 0.
  - ENTRY:
    - Digit: shift into entry register; digit_cnt + 1.
    - '*': digit_cnt = 0, stay in ENTRY.
    - '#': -> IDLE, no failure counted.
    - On the DIGITS-th digit, compare with code:
      - Match -> OPEN; fail_cnt = 0.
      - Mismatch -> err pulse; fail_cnt + 1. If the new value == MAX_FAIL -> LOCKOUT, else -> IDLE.
  - OPEN:
    - open = 1; timer loads OPEN_CYC on entry.
    - '#' -> PROG.
    - Timer expiry -> IDLE.
    - Expiry and '#' in the same cycle: expiry wins.
  - PROG:
    - Collect DIGITS digits into the shadow register, then -> CONFIRM with digit_cnt = 0.
    - '*' or '#' aborts to IDLE; code unchanged.
  - CONFIRM:
    - Collect DIGITS digits.
    - Match with shadow: code = shadow; code_chg pulse; -> IDLE.
    - Mismatch: err pulse; -> IDLE; code unchanged.
    - '*' or '#' aborts to IDLE.
  - LOCKOUT:
    - Timer loads LOCKOUT_CYC on entry; all key events are discarded.
    - Expiry -> IDLE with fail_cnt = 0. fail_cnt holds MAX_FAIL until then.
- digit_cnt resets to 0 on every state change.
- fail_cnt saturates at MAX_FAIL and is not cleared by '#' aborts.
- Timers:
  - Down-counters of width $clog2(max(OPEN_CYC, LOCKOUT_CYC)+1).
  - Expiry means count == 1 while decrementing; state dwells exactly N cycles.
- Undefined state encodings -> IDLE.

Optional Feature:
LOCK_TAMPER_ALARM_EN
- Defined: extra output port alarm (1 bit, reset 0). Set on entry to LOCKOUT; stays set through LOCKOUT and IDLE; cleared only on entry to OPEN.
- Undefined: alarm port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package lock_pkg holds:
  - state enum: IDLE, ENTRY, OPEN, PROG, CONFIRM, LOCKOUT
  - key code constants KEY_HASH = 4'd10, KEY_STAR = 4'd11
  - key_n -> key-code decode function with a valid flag
- Sub-module lock_key_scan contains the synchronizer, one-hot-low decode, rel_cnt and release-armed logic. It outputs key_vld (1-cycle) and key_code (4 bits).

Test Plan:
All scenarios use REL_CYC=4, OPEN_CYC=20, LOCKOUT_CYC=30, MAX_FAIL=3. Every key is pressed 3 cycles, then released for 6 or more cycles.
1. *,4,8,1 -> open = 1 for exactly 20 cycles, then 0; fail_cnt = 0; err never pulses.
2. *,4,8,2 three times -> err pulses 3 times; fail_cnt goes 1, 2; lockout = 1 for 30 cycles; *,4,8,1 during lockout -> open stays 0; after expiry, fail_cnt = 0.
3. *,4,8,1 then #,1,2,3,1,2,3 -> prog_mode high during programming; code_chg single-cycle pulse; *,4,8,1 -> err; *,1,2,3 -> open = 1.
4. Open, then #,1,2,3,1,2,4 -> err pulse, no code_chg; *,4,8,1 still opens.
5. Hold key 4 for 40 cycles -> digit_cnt increments once. key_n = 12'hFF6 (two keys) -> no event. Release for only 3 cycles between keys -> second key ignored.
6. *,4 then assert n_reset mid-press -> all outputs 0 immediately; after release of reset, *,4,8,1 opens (code = INIT_CODE).

Source files
------------

// File: rtl/lock_pkg.sv
// lock_pkg: shared types, key-code constants and the raw keypad decoder
// used by the door-lock access controller.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        OPEN    = 3'd2,
        PROG    = 3'd3,
        CONFIRM = 3'd4,
        LOCKOUT = 3'd5
    } lock_state_e;

    localparam logic [3:0] KEY_HASH = 4'd10;
    localparam logic [3:0] KEY_STAR = 4'd11;

    typedef struct packed {
        logic       vld;
        logic [3:0] code;
    } key_dec_t;

    // A pattern is a valid key only when exactly one active-low line is
    // asserted; bits 0-8 are digits 1-9, bit 9 is digit 0, then '#', '*'.
    function automatic key_dec_t decode_key(input logic [11:0] keyN);
        key_dec_t res;
        int       lowCnt;
        res    = '0;
        lowCnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (!keyN[i]) begin
                lowCnt = lowCnt + 1;
                if (i < 9)
                    res.code = 4'(i + 1);
                else if (i == 9)
                    res.code = 4'd0;
                else if (i == 10)
                    res.code = KEY_HASH;
                else
                    res.code = KEY_STAR;
            end
        end
        res.vld = (lowCnt == 1);
        return res;
    endfunction

endpackage

// File: rtl/lock_code_ctrl_key_scan.sv
// lock_key_scan: synchronizes the raw keypad, decodes single-key presses
// and only re-arms after the keypad has been fully released long enough.
module lock_key_scan
    import lock_pkg::*;
#(
    parameter int unsigned REL_CYC = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [11:0] key_n,
    output logic        key_vld,
    output logic [3:0]  key_code
);

    localparam int RW = $clog2(REL_CYC + 1);

    logic [11:0]   sync1_q;
    logic [11:0]   sync2_q;
    logic [RW-1:0] rel_cnt_q;
    logic          armed_q;
    key_dec_t      keyDec;

    assign keyDec   = decode_key(sync2_q);
    assign key_vld  = keyDec.vld & armed_q;
    assign key_code = keyDec.code;

    // Two-flop synchronizer; resets to the all-released pattern.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q <= 12'hFFF;
            sync2_q <= 12'hFFF;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    // Release counter saturates at REL_CYC; any pressed line restarts it.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            rel_cnt_q <= '0;
        else if (sync2_q != 12'hFFF)
            rel_cnt_q <= '0;
        else if (rel_cnt_q != RW'(REL_CYC))
            rel_cnt_q <= rel_cnt_q + RW'(1);
    end

    // An accepted key disarms the scanner until a long enough full release.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            armed_q <= 1'b1;
        else if (key_vld)
            armed_q <= 1'b0;
        else if (rel_cnt_q == RW'(REL_CYC))
            armed_q <= 1'b1;
    end

endmodule

// File: rtl/lock_code_ctrl.sv
// lock_code_ctrl: keypad access controller with code entry, failure
// lockout, timed open window and a program/confirm code-change flow.
// Optional build macro LOCK_TAMPER_ALARM_EN adds a sticky 'alarm' output.
module lock_code_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned       DIGITS      = 3,
    parameter logic [DIGITS*4-1:0] INIT_CODE = 12'h481,
    parameter int unsigned       REL_CYC     = 24'hFFFFFF,
    parameter int unsigned       OPEN_CYC    = 50000000,
    parameter int unsigned       MAX_FAIL    = 3,
    parameter int unsigned       LOCKOUT_CYC = 250000000
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic [11:0]                   key_n,
    output logic                          open,
    output logic                          lockout,
    output logic                          prog_mode,
    output logic [2:0]                    digit_cnt,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt,
    output logic                          code_chg,
    output logic                          err
`ifdef LOCK_TAMPER_ALARM_EN
   ,output logic                          alarm
`endif
);

    localparam int          CW   = DIGITS * 4;
    localparam int          FW   = $clog2(MAX_FAIL + 1);
    localparam int unsigned TMAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int          TW   = $clog2(TMAX + 1);

    logic          key_vld;
    logic [3:0]    key_code;

    lock_state_e   state_q, state_d;
    logic [CW-1:0] code_q, entry_q, shadow_q;
    logic [2:0]    digit_cnt_q;
    logic [FW-1:0] fail_q;
    logic [TW-1:0] timer_q;
    logic          open_q, lockout_q, prog_q, code_chg_q, err_q;

    logic          isDigit, isStar, isHash, lastDigit, timerExpire;
    logic          entryMatch, confirmMatch;
    logic [CW-1:0] entryNext, shadowNext;
    logic [FW-1:0] failInc;

    lock_key_scan #(.REL_CYC(REL_CYC)) u_key_scan (
        .clk      (clk),
        .n_reset  (n_reset),
        .key_n    (key_n),
        .key_vld  (key_vld),
        .key_code (key_code)
    );

    // Key classification, shifted entry values and comparison results.
    always_comb begin
        isDigit      = key_vld && (key_code <= 4'd9);
        isStar       = key_vld && (key_code == KEY_STAR);
        isHash       = key_vld && (key_code == KEY_HASH);
        lastDigit    = isDigit && (digit_cnt_q == 3'(DIGITS - 1));
        timerExpire  = (timer_q == TW'(1));
        entryNext    = CW'({entry_q, key_code});
        shadowNext   = CW'({shadow_q, key_code});
        entryMatch   = (entryNext == code_q);
        confirmMatch = (entryNext == shadow_q);
        failInc      = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + FW'(1);
    end

    // Next-state decode; events not handled by a state are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (isStar) state_d = ENTRY;
            ENTRY: begin
                if (isHash)
                    state_d = IDLE;
                else if (lastDigit) begin
                    if (entryMatch)
                        state_d = OPEN;
                    else if (failInc == FW'(MAX_FAIL))
                        state_d = LOCKOUT;
                    else
                        state_d = IDLE;
                end
            end
            OPEN: begin
                if (timerExpire)
                    state_d = IDLE;
                else if (isHash)
                    state_d = PROG;
            end
            PROG: begin
                if (isStar || isHash)
                    state_d = IDLE;
                else if (lastDigit)
                    state_d = CONFIRM;
            end
            CONFIRM: if (isStar || isHash || lastDigit) state_d = IDLE;
            LOCKOUT: if (timerExpire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, datapath registers and Moore outputs registered from next state.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= IDLE;
            code_q      <= INIT_CODE;
            entry_q     <= '0;
            shadow_q    <= '0;
            digit_cnt_q <= '0;
            fail_q      <= '0;
            timer_q     <= '0;
            open_q      <= 1'b0;
            lockout_q   <= 1'b0;
            prog_q      <= 1'b0;
            code_chg_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            open_q    <= (state_d == OPEN);
            lockout_q <= (state_d == LOCKOUT);
            prog_q    <= (state_d == PROG) || (state_d == CONFIRM);

            if (state_d != state_q)
                digit_cnt_q <= '0;
            else if ((state_q == ENTRY) && isStar)
                digit_cnt_q <= '0;
            else if (((state_q == ENTRY) || (state_q == PROG) || (state_q == CONFIRM)) && isDigit)
                digit_cnt_q <= digit_cnt_q + 3'd1;

            if (((state_q == ENTRY) || (state_q == CONFIRM)) && isDigit)
                entry_q <= entryNext;
            if ((state_q == PROG) && isDigit)
                shadow_q <= shadowNext;

            err_q      <= lastDigit && (((state_q == ENTRY) && !entryMatch) ||
                                        ((state_q == CONFIRM) && !confirmMatch));
            code_chg_q <= lastDigit && (state_q == CONFIRM) && confirmMatch;
            if (lastDigit && (state_q == CONFIRM) && confirmMatch)
                code_q <= shadow_q;

            if ((state_q == ENTRY) && lastDigit)
                fail_q <= entryMatch ? '0 : failInc;
            else if ((state_q == LOCKOUT) && timerExpire)
                fail_q <= '0;

            if ((state_d == OPEN) && (state_q != OPEN))
                timer_q <= TW'(OPEN_CYC);
            else if ((state_d == LOCKOUT) && (state_q != LOCKOUT))
                timer_q <= TW'(LOCKOUT_CYC);
            else if (timer_q != '0)
                timer_q <= timer_q - TW'(1);
        end
    end

`ifdef LOCK_TAMPER_ALARM_EN
    logic alarm_q;

    // Sticky tamper flag: raised entering lockout, dropped only on a good open.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            alarm_q <= 1'b0;
        else if ((state_d == LOCKOUT) && (state_q != LOCKOUT))
            alarm_q <= 1'b1;
        else if ((state_d == OPEN) && (state_q != OPEN))
            alarm_q <= 1'b0;
    end

    assign alarm = alarm_q;
`endif

    assign open      = open_q;
    assign lockout   = lockout_q;
    assign prog_mode = prog_q;
    assign digit_cnt = digit_cnt_q;
    assign fail_cnt  = fail_q;
    assign code_chg  = code_chg_q;
    assign err       = err_q;

endmodule
